dcache_tag_walker: RTL and testbench
====================================

# dcache_tag_walker

Tag-memory walker for the data cache: on request it scans every tag-FIFO location, issues a writeback request for each valid+dirty line, clears that line's dirty bit through the FIFO's tag-update port and, optionally, flushes (invalidates) the FIFO at the end. It is the read/consumer side of the tag FIFO, sitting between the dcache controller (fence / flush / clean commands) and the line writeback path.

## Interface
Parameters:
- WD, 8: tag-memory entry width; must equal width of type_dcache_tag_mem_s.
- DP, 4: tag-FIFO depth, power of 2, 4..256. AW = $clog2(DP).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- walk_req  in  1  start walk; level, sampled only in IDLE.
- walk_inv  in  1  1 = invalidate after walk (pulse tw_flush); sampled with walk_req.
- walk_busy  out  1  high from the cycle after acceptance until DONE inclusive.
- walk_done  out  1  one-cycle pulse at walk completion.
- wb_cnt  out  AW+1  writebacks issued in current/last walk.
- tag_empty  in  1  tag-FIFO empty flag.
- tw_rptr  out  AW  tag read/scan pointer.
- tw_rdata  in  WD  tag_mem[tw_rptr], combinational (type_dcache_tag_mem_s).
- tw_uwr  out  1  tag update strobe (drives FIFO tag_uwr).
- tw_uptr  out  AW  update location (drives FIFO tag_uptr).
- tw_wdata  out  WD  update data: valid=1, dirty=0, tag unchanged.
- tw_flush  out  1  one-cycle FIFO flush pulse.
- wb_req  out  1  writeback request, held until wb_ack.
- wb_index  out  AW  tag location being written back.
- wb_tag  out  TAG_XLEN  tag of the line being written back.
- wb_ack  in  1  writeback accepted; ignored when wb_req low.

## Operation
- Entry layout: bit WD-1 valid, bit WD-2 dirty, bits WD-3:0 tag.
- States: IDLE, SCAN, WB, CLEAN, END.
- IDLE: walk_req=1 -> latch walk_inv, clear wb_cnt, tw_rptr=0; tag_empty=1 -> END, else -> SCAN.
- SCAN: entry at tw_rptr valid && dirty -> latch wb_index=tw_rptr, wb_tag=tag -> WB. Otherwise: tw_rptr==DP-1 -> END, else tw_rptr+1, stay SCAN.
- WB: wb_req=1; wb_ack=1 -> CLEAN, wb_cnt+1.
- CLEAN: tw_uwr=1 for exactly one cycle, tw_uptr=wb_index, tw_wdata={1,0,wb_tag}; then tw_rptr==DP-1 -> END, else tw_rptr+1 -> SCAN.
- END: walk_done=1; tw_flush=1 if latched walk_inv; -> IDLE.
- Scan always covers all DP locations; invalid entries are skipped, tw_rptr never wraps during a walk.
- Controller holds off tag_wr/tag_uwr while walk_busy (FIFO gives tag_wr priority over tag_uwr; a concurrent write would drop the clean).
- walk_req while busy ignored; walk_req still high in IDLE after END starts a new walk.
- wb_cnt holds its value after END until next accepted walk_req.

## Timing
- Reset (cycle-synchronous): state IDLE; walk_busy, walk_done, wb_req, tw_uwr, tw_flush = 0; tw_rptr, tw_uptr, wb_index, wb_tag, wb_cnt = 0; tw_wdata = 0.
- Reset mid-walk: abort at next edge, all outputs as above, no further update/flush; the writeback path drops any outstanding request.
- Clean entry: 1 cycle. Dirty entry: 1 (SCAN) + N (WB, N≥1 incl. ack cycle) + 1 (CLEAN).
- Empty FIFO: walk_req -> END next cycle -> walk_done the cycle after (2 cycles).
- No dirty entries: walk_done DP+1 cycles after acceptance.
- wb_req/wb_index/wb_tag stable from WB entry until the cycle wb_ack is sampled high; wb_ack same cycle as wb_req rise is legal.
- All outputs registered or decoded from state/registers only; no combinational input->output paths except none.

## Structure
- type_dcache_tag_mem_s and `TAG_XLEN stay in cache_defs.svh; add state enum type_dcache_walk_st there.
- Single module, no sub-modules; instantiated beside dcache_tag_fifo with tw_* wired to its ports and tw_flush ORed into its flush.

## Test plan
- DP=4, FIFO empty, walk_req=1, walk_inv=1 -> walk_done and tw_flush pulse 2 cycles later, wb_req never high, wb_cnt=0.
- DP=4, entries {V,clean,0x10},{V,dirty,0x21},{invalid},{V,dirty,0x33}, wb_ack 2 cycles after each req -> wb_req for index1 tag 0x21 then index3 tag 0x33, tw_uwr at uptr 1 then 3 with dirty=0, wb_cnt=2, no tw_flush (walk_inv=0).
- Same contents, walk_inv=1 -> identical sequence plus tw_flush coincident with walk_done; FIFO empty afterwards.
- wb_ack held low 20 cycles -> wb_req, wb_index, wb_tag stable throughout, walk_busy=1, no tw_uwr until ack.
- reset asserted in WB state -> next cycle all outputs at reset values, no tw_uwr/tw_flush; subsequent walk_req completes normally.
- walk_req held high continuously, all clean -> back-to-back walks, walk_done every DP+2 cycles, walk_req during busy ignored.

Source files
------------

// File: rtl/dcache_tag_walker_pkg.sv
// -----------------------------------------------------------------------------
// dcache_tag_walker_pkg
// Shared types for the data-cache tag walker and the tag FIFO it drives.
//   TAG_XLEN               : width of the tag field in a tag-memory entry
//   type_dcache_tag_mem_s  : one tag-memory entry {valid, dirty, tag}
//   type_dcache_walk_st    : walker FSM states
// -----------------------------------------------------------------------------
package dcache_tag_walker_pkg;

    localparam int TAG_XLEN = 6;

    typedef struct packed {
        logic                valid;
        logic                dirty;
        logic [TAG_XLEN-1:0] tag;
    } type_dcache_tag_mem_s;

    typedef enum logic [2:0] {
        WALK_IDLE,
        WALK_SCAN,
        WALK_WB,
        WALK_CLEAN,
        WALK_END
    } type_dcache_walk_st;

endpackage

// File: rtl/dcache_tag_walker.sv
// -----------------------------------------------------------------------------
// dcache_tag_walker
// Scans every tag-FIFO location once per walk. Each valid+dirty line gets a
// writeback request; once accepted, the line's dirty bit is cleared through
// the FIFO tag-update port. Optionally pulses a FIFO flush at the end.
//
// Ports
//   clk, reset         : clock, synchronous active-high reset
//   walk_req/walk_inv  : start a walk / invalidate FIFO after the walk
//   walk_busy          : walk in progress (through the walk_done cycle)
//   walk_done          : one-cycle completion pulse
//   wb_cnt             : writebacks issued in the current/last walk
//   tag_empty          : tag-FIFO empty flag
//   tw_rptr/tw_rdata   : scan pointer and combinational tag read data
//   tw_uwr/tw_uptr/tw_wdata : tag update strobe, location, data
//   tw_flush           : one-cycle FIFO flush pulse
//   wb_req/wb_index/wb_tag/wb_ack : writeback handshake
// -----------------------------------------------------------------------------
module dcache_tag_walker
    import dcache_tag_walker_pkg::*;
#(
    parameter int WD = 8,
    parameter int DP = 4,
    localparam int AW = $clog2(DP)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                walk_req,
    input  logic                walk_inv,
    output logic                walk_busy,
    output logic                walk_done,
    output logic [AW:0]         wb_cnt,
    input  logic                tag_empty,
    output logic [AW-1:0]       tw_rptr,
    input  logic [WD-1:0]       tw_rdata,
    output logic                tw_uwr,
    output logic [AW-1:0]       tw_uptr,
    output logic [WD-1:0]       tw_wdata,
    output logic                tw_flush,
    output logic                wb_req,
    output logic [AW-1:0]       wb_index,
    output logic [TAG_XLEN-1:0] wb_tag,
    input  logic                wb_ack
);

    localparam logic [AW-1:0] LAST_PTR = AW'(DP - 1);

    type_dcache_walk_st   state_q, state_d;
    logic [AW-1:0]        rptr_q, rptr_d;
    logic [AW-1:0]        uptr_q, uptr_d;
    logic [AW-1:0]        wb_index_q, wb_index_d;
    logic [TAG_XLEN-1:0]  wb_tag_q, wb_tag_d;
    logic [AW:0]          wb_cnt_q, wb_cnt_d;
    type_dcache_tag_mem_s wdata_q, wdata_d;
    logic                 inv_q, inv_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 flush_q, flush_d;
    logic                 wb_req_q, wb_req_d;
    logic                 uwr_q, uwr_d;

    type_dcache_tag_mem_s rd_entry;
    logic                 at_last;

    assign rd_entry = type_dcache_tag_mem_s'(tw_rdata);
    assign at_last  = (rptr_q == LAST_PTR);

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves one unassigned (no latch).
        state_d    = state_q;
        rptr_d     = rptr_q;
        uptr_d     = uptr_q;
        wb_index_d = wb_index_q;
        wb_tag_d   = wb_tag_q;
        wb_cnt_d   = wb_cnt_q;
        wdata_d    = wdata_q;
        inv_d      = inv_q;

        case (state_q)
            WALK_IDLE: begin
                if (walk_req) begin
                    inv_d    = walk_inv;
                    wb_cnt_d = '0;
                    rptr_d   = '0;
                    state_d  = tag_empty ? WALK_END : WALK_SCAN;
                end
            end
            WALK_SCAN: begin
                if (rd_entry.valid && rd_entry.dirty) begin
                    wb_index_d = rptr_q;
                    wb_tag_d   = rd_entry.tag;
                    state_d    = WALK_WB;
                end else if (at_last) begin
                    state_d = WALK_END;
                end else begin
                    rptr_d = rptr_q + AW'(1);
                end
            end
            WALK_WB: begin
                if (wb_ack) begin
                    wb_cnt_d = wb_cnt_q + (AW+1)'(1);
                    uptr_d   = wb_index_q;
                    wdata_d  = '{valid: 1'b1, dirty: 1'b0, tag: wb_tag_q};
                    state_d  = WALK_CLEAN;
                end
            end
            WALK_CLEAN: begin
                // Resume the scan after the cleaned line; never wrap past the end.
                if (at_last) begin
                    state_d = WALK_END;
                end else begin
                    rptr_d  = rptr_q + AW'(1);
                    state_d = WALK_SCAN;
                end
            end
            WALK_END: begin
                state_d = WALK_IDLE;
            end
            default: begin
                state_d = WALK_IDLE;
            end
        endcase

        // Strobes that live with a state are decoded from the next state so they
        // line up with it; done/flush follow the END cycle by one, and busy
        // stays up through that done cycle.
        wb_req_d = (state_d == WALK_WB);
        uwr_d    = (state_d == WALK_CLEAN);
        done_d   = (state_q == WALK_END);
        flush_d  = (state_q == WALK_END) && inv_q;
        busy_d   = (state_d != WALK_IDLE) || (state_q == WALK_END);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= WALK_IDLE;
            rptr_q     <= '0;
            uptr_q     <= '0;
            wb_index_q <= '0;
            wb_tag_q   <= '0;
            wb_cnt_q   <= '0;
            wdata_q    <= '0;
            inv_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            flush_q    <= 1'b0;
            wb_req_q   <= 1'b0;
            uwr_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge _d values together.
            state_q    <= state_d;
            rptr_q     <= rptr_d;
            uptr_q     <= uptr_d;
            wb_index_q <= wb_index_d;
            wb_tag_q   <= wb_tag_d;
            wb_cnt_q   <= wb_cnt_d;
            wdata_q    <= wdata_d;
            inv_q      <= inv_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            flush_q    <= flush_d;
            wb_req_q   <= wb_req_d;
            uwr_q      <= uwr_d;
        end
    end

    assign walk_busy = busy_q;
    assign walk_done = done_q;
    assign wb_cnt    = wb_cnt_q;
    assign tw_rptr   = rptr_q;
    assign tw_uwr    = uwr_q;
    assign tw_uptr   = uptr_q;
    assign tw_wdata  = wdata_q;
    assign tw_flush  = flush_q;
    assign wb_req    = wb_req_q;
    assign wb_index  = wb_index_q;
    assign wb_tag    = wb_tag_q;

endmodule

// File: tb/tb_dcache_tag_walker.sv
// -----------------------------------------------------------------------------
// tb_dcache_tag_walker
// Bench for dcache_tag_walker with DP=4. Holds a tag-FIFO model (array +
// empty flag, update port, flush), a writeback responder with programmable
// ack delay, and an expected-result model derived from the walk rules.
// -----------------------------------------------------------------------------
module tb_dcache_tag_walker;
    import dcache_tag_walker_pkg::*;

    localparam int WD = 8;
    localparam int DP = 4;
    localparam int AW = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                walk_req;
    logic                walk_inv;
    logic                walk_busy;
    logic                walk_done;
    logic [AW:0]         wb_cnt;
    logic                tag_empty;
    logic [AW-1:0]       tw_rptr;
    logic [WD-1:0]       tw_rdata;
    logic                tw_uwr;
    logic [AW-1:0]       tw_uptr;
    logic [WD-1:0]       tw_wdata;
    logic                tw_flush;
    logic                wb_req;
    logic [AW-1:0]       wb_index;
    logic [TAG_XLEN-1:0] wb_tag;
    logic                wb_ack = 1'b0;

    dcache_tag_walker #(.WD(WD), .DP(DP)) dut (
        .clk       (clk),
        .reset     (reset),
        .walk_req  (walk_req),
        .walk_inv  (walk_inv),
        .walk_busy (walk_busy),
        .walk_done (walk_done),
        .wb_cnt    (wb_cnt),
        .tag_empty (tag_empty),
        .tw_rptr   (tw_rptr),
        .tw_rdata  (tw_rdata),
        .tw_uwr    (tw_uwr),
        .tw_uptr   (tw_uptr),
        .tw_wdata  (tw_wdata),
        .tw_flush  (tw_flush),
        .wb_req    (wb_req),
        .wb_index  (wb_index),
        .wb_tag    (wb_tag),
        .wb_ack    (wb_ack)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // ---------------- tag FIFO model ----------------
    logic [WD-1:0] mem [DP];
    logic          fifo_empty = 1'b1;
    logic [WD-1:0] load_img [DP];
    logic          load_en    = 1'b0;
    logic          load_empty = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load_en) begin
            for (int i = 0; i < DP; i++) mem[i] <= load_img[i];
            fifo_empty <= load_empty;
        end else begin
            if (tw_uwr) mem[tw_uptr] <= tw_wdata;
            if (tw_flush) begin
                for (int i = 0; i < DP; i++) mem[i] <= '0;
                fifo_empty <= 1'b1;
            end
        end
    end

    assign tw_rdata  = mem[tw_rptr];
    assign tag_empty = fifo_empty;

    // ---------------- responder / monitor ----------------
    int                  ack_delay = 0;
    int                  wb_age    = 0;
    logic                prev_req  = 1'b0;
    logic                ack_taken = 1'b0;
    logic [AW-1:0]       ref_idx;
    logic [TAG_XLEN-1:0] ref_tag;
    int                  wb_idx_log[$];
    int                  wb_tag_log[$];
    int                  uwr_ptr_log[$];
    int                  uwr_dat_log[$];
    int                  flush_cnt = 0;
    int                  proto_err = 0;

    // NOTE: outputs are sampled on the falling edge, half a cycle clear of the active edge.
    always @(negedge clk) begin
        wb_ack = 1'b0;
        if (reset) begin
            prev_req  = 1'b0;
            ack_taken = 1'b0;
        end else begin
            if (wb_req) begin
                if (!prev_req) begin
                    wb_idx_log.push_back(int'(wb_index));
                    wb_tag_log.push_back(int'(wb_tag));
                    ref_idx = wb_index;
                    ref_tag = wb_tag;
                    wb_age  = 0;
                end else if (wb_index !== ref_idx || wb_tag !== ref_tag) begin
                    proto_err++;
                end
                if (walk_busy !== 1'b1) proto_err++;
                if (wb_age == ack_delay) wb_ack = 1'b1;
                wb_age++;
            end
            if (tw_uwr) begin
                uwr_ptr_log.push_back(int'(tw_uptr));
                uwr_dat_log.push_back(int'(tw_wdata));
                if (!ack_taken) proto_err++;
            end
            if (tw_flush) begin
                flush_cnt++;
                if (walk_done !== 1'b1) proto_err++;
            end
            if (walk_done === 1'b1 && walk_busy !== 1'b1) proto_err++;
            ack_taken = wb_req && wb_ack;
            prev_req  = wb_req;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wb_idx_log.delete();
        wb_tag_log.delete();
        uwr_ptr_log.delete();
        uwr_dat_log.delete();
        flush_cnt = 0;
        proto_err = 0;
    endtask

    task automatic load_fifo(input logic empty);
        load_empty = empty;
        load_en    = 1'b1;
        @(negedge clk);
        load_en    = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        check($sformatf("%s walk_busy", name), walk_busy, 0);
        check($sformatf("%s walk_done", name), walk_done, 0);
        check($sformatf("%s wb_req", name),    wb_req,    0);
        check($sformatf("%s tw_uwr", name),    tw_uwr,    0);
        check($sformatf("%s tw_flush", name),  tw_flush,  0);
        check($sformatf("%s tw_rptr", name),   tw_rptr,   0);
        check($sformatf("%s tw_uptr", name),   tw_uptr,   0);
        check($sformatf("%s wb_index", name),  wb_index,  0);
        check($sformatf("%s wb_tag", name),    wb_tag,    0);
        check($sformatf("%s wb_cnt", name),    wb_cnt,    0);
        check($sformatf("%s tw_wdata", name),  tw_wdata,  0);
    endtask

    // One walk from IDLE, compared against a reference derived from the rules:
    // every location visited in order, clean/invalid costs 1 cycle, dirty costs
    // SCAN + (delay+1) WB cycles + CLEAN, plus 2 for acceptance and END.
    task automatic run_walk(input string name, input logic inv, input int delay);
        logic [WD-1:0] pre [DP];
        logic [WD-1:0] exp_mem [DP];
        logic          pre_empty;
        logic          exp_empty;
        int            exp_wb[$];
        int            exp_lat;
        int            c0;
        int            n;

        for (int i = 0; i < DP; i++) pre[i] = mem[i];
        pre_empty = fifo_empty;
        exp_lat   = 2;
        if (!pre_empty) begin
            for (int i = 0; i < DP; i++) begin
                if (pre[i][WD-1] && pre[i][WD-2]) begin
                    exp_wb.push_back(i);
                    exp_lat += delay + 3;
                end else begin
                    exp_lat += 1;
                end
            end
        end
        for (int i = 0; i < DP; i++) exp_mem[i] = pre[i];
        foreach (exp_wb[j]) exp_mem[exp_wb[j]][WD-2] = 1'b0;
        exp_empty = pre_empty;
        if (inv) begin
            for (int i = 0; i < DP; i++) exp_mem[i] = '0;
            exp_empty = 1'b1;
        end

        clear_logs();
        ack_delay = delay;
        walk_req  = 1'b1;
        walk_inv  = inv;
        c0        = cyc;
        @(negedge clk);
        walk_req  = 1'b0;
        walk_inv  = 1'b0;
        for (int k = 0; k < 300 && walk_done !== 1'b1; k++) @(negedge clk);

        check($sformatf("%s walk_done seen", name), walk_done, 1);
        check($sformatf("%s latency", name), cyc - c0, exp_lat);
        check($sformatf("%s flush with done", name), tw_flush, inv);
        check($sformatf("%s wb_cnt", name), wb_cnt, exp_wb.size());
        check($sformatf("%s wb_req count", name), wb_idx_log.size(), exp_wb.size());
        n = (wb_idx_log.size() < exp_wb.size()) ? wb_idx_log.size() : exp_wb.size();
        for (int j = 0; j < n; j++) begin
            check($sformatf("%s wb_index[%0d]", name, j), wb_idx_log[j], exp_wb[j]);
            check($sformatf("%s wb_tag[%0d]", name, j), wb_tag_log[j],
                  int'(pre[exp_wb[j]][TAG_XLEN-1:0]));
        end
        check($sformatf("%s tw_uwr count", name), uwr_ptr_log.size(), exp_wb.size());
        n = (uwr_ptr_log.size() < exp_wb.size()) ? uwr_ptr_log.size() : exp_wb.size();
        for (int j = 0; j < n; j++) begin
            check($sformatf("%s tw_uptr[%0d]", name, j), uwr_ptr_log[j], exp_wb[j]);
            check($sformatf("%s tw_wdata[%0d]", name, j), uwr_dat_log[j],
                  int'({2'b10, pre[exp_wb[j]][TAG_XLEN-1:0]}));
        end

        @(negedge clk);
        check($sformatf("%s busy after done", name), walk_busy, 0);
        check($sformatf("%s flush count", name), flush_cnt, inv ? 1 : 0);
        check($sformatf("%s fifo empty", name), fifo_empty, exp_empty);
        for (int i = 0; i < DP; i++)
            check($sformatf("%s tag_mem[%0d]", name, i), mem[i], exp_mem[i]);
        check($sformatf("%s protocol", name), proto_err, 0);
    endtask

    // ---------------- stimulus ----------------
    int done_cyc[3];
    int n_done;

    initial begin
        reset    = 1'b1;
        walk_req = 1'b0;
        walk_inv = 1'b0;
        for (int i = 0; i < DP; i++) load_img[i] = '0;
        load_fifo(1'b1);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        check("idle busy", walk_busy, 0);

        // Empty FIFO with invalidate.
        run_walk("empty_inv", 1'b1, 0);

        // {V,clean,0x10}, {V,dirty,0x21}, {invalid,dirty bit set}, {V,dirty,0x33}
        load_img[0] = 8'h90;
        load_img[1] = 8'hE1;
        load_img[2] = 8'h7F;
        load_img[3] = 8'hF3;
        load_fifo(1'b0);
        run_walk("dirty_noinv", 1'b0, 2);

        load_fifo(1'b0);
        run_walk("dirty_inv", 1'b1, 2);

        // Slow writeback path.
        load_fifo(1'b0);
        run_walk("stall20", 1'b0, 20);

        // Reset while waiting in WB.
        load_fifo(1'b0);
        clear_logs();
        ack_delay = 50;
        walk_req  = 1'b1;
        @(negedge clk);
        walk_req  = 1'b0;
        for (int k = 0; k < 20 && wb_req !== 1'b1; k++) @(negedge clk);
        check("rst_mid wb_req seen", wb_req, 1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_mid no update", uwr_ptr_log.size(), 0);
        check("rst_mid no flush", flush_cnt, 0);
        check("rst_mid still idle", walk_busy, 0);
        for (int i = 0; i < DP; i++)
            check($sformatf("rst_mid tag_mem[%0d]", i), mem[i], load_img[i]);
        run_walk("post_rst", 1'b0, 1);

        // Back-to-back walks with walk_req held high, all entries clean.
        load_img[0] = 8'h80;
        load_img[1] = 8'h85;
        load_img[2] = 8'h8A;
        load_img[3] = 8'hBF;
        load_fifo(1'b0);
        clear_logs();
        ack_delay = 0;
        walk_req  = 1'b1;
        n_done    = 0;
        for (int k = 0; k < 60 && n_done < 3; k++) begin
            @(negedge clk);
            if (walk_done === 1'b1) begin
                done_cyc[n_done] = cyc;
                n_done++;
            end
        end
        walk_req = 1'b0;
        check("b2b done count", n_done, 3);
        check("b2b period 1", done_cyc[1] - done_cyc[0], DP + 2);
        check("b2b period 2", done_cyc[2] - done_cyc[1], DP + 2);
        check("b2b no wb", wb_idx_log.size(), 0);
        check("b2b wb_cnt", wb_cnt, 0);
        for (int k = 0; k < 20 && walk_busy !== 1'b0; k++) @(negedge clk);
        check("b2b idle", walk_busy, 0);

        // Randomised contents, ack delays and invalidate.
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < DP; i++) load_img[i] = WD'($urandom);
            load_fifo($urandom_range(0, 5) == 0);
            run_walk($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
